// File: rtl/trackball_pkg.sv
// Shared defaults, axis state encoding and accumulator saturation limits for trackball_quad.
package trackball_pkg;

  localparam int unsigned ACC_W_DEF    = 12;
  localparam int unsigned STEP_DIV_DEF = 64;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STEP
  } axis_state_t;

  // Symmetric clamp: the most negative code is never produced.
  function automatic int sat_hi(input int unsigned acc_w);
    return (1 << (acc_w - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int unsigned acc_w);
    return -sat_hi(acc_w);
  endfunction

endpackage

// File: rtl/trackball_axis.sv
// One trackball axis: saturating accumulator plus dir/clk step engine driven by the shared tick.
module trackball_axis
  import trackball_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               tick,
  input  logic               hold,
  input  logic signed [ACC_W:0] inc,
  output logic               dir,
  output logic               step_clk
);

  localparam int unsigned SUM_W = ACC_W + 2;
  localparam logic signed [SUM_W-1:0] HI = SUM_W'(sat_hi(ACC_W));
  localparam logic signed [SUM_W-1:0] LO = SUM_W'(sat_lo(ACC_W));

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [SUM_W-1:0] acc_ext_c;
  logic signed [SUM_W-1:0] inc_ext_c;
  logic signed [SUM_W-1:0] consume_c;
  logic signed [SUM_W-1:0] sum_c;
  axis_state_t             state_c;

  // Step decision, consumption and the single saturating accumulator update.
  always_comb begin
    state_c   = IDLE;
    consume_c = '0;
    acc_ext_c = SUM_W'(acc_q);
    inc_ext_c = SUM_W'(inc);
    if (acc_q != '0) begin
      state_c = (acc_q[ACC_W-1] != dir) ? STEP : SETUP;
    end
    if (tick && !hold && (state_c == STEP)) begin
      consume_c = dir ? SUM_W'(1) : {SUM_W{1'b1}};
    end
    sum_c = acc_ext_c + inc_ext_c - consume_c;
    if (hold) begin
      acc_d = '0;
    end else if (sum_c > HI) begin
      acc_d = ACC_W'(HI);
    end else if (sum_c < LO) begin
      acc_d = ACC_W'(LO);
    end else begin
      acc_d = sum_c[ACC_W-1:0];
    end
  end

  // SETUP only moves dir, so dir is settled a full tick before the next clk edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      dir      <= 1'b0;
      step_clk <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (tick && !hold) begin
        case (state_c)
          SETUP:   dir      <= ~acc_q[ACC_W-1];
          STEP:    step_clk <= ~step_clk;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/trackball_quad.sv
// PS/2 mouse packets to Centipede trackball dir/clk pairs, rate limited by a shared prescaler.
// Define TRACKBALL_JOY_EN to add the joy_i port that nudges both axes once per tick.
module trackball_quad
  import trackball_pkg::*;
#(
  parameter int unsigned ACC_W    = ACC_W_DEF,
  parameter int unsigned STEP_DIV = STEP_DIV_DEF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [24:0] ps2_mouse,
  input  logic        flip,
  input  logic        hold,
`ifdef TRACKBALL_JOY_EN
  input  logic [3:0]  joy_i,
`endif
  output logic [3:0]  trakdata
);

  localparam int unsigned DW    = ACC_W + 1;
  localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [CNT_W-1:0]     cnt_q;
  logic                 tick_c;
  logic                 strobe_q;
  logic                 armed_q;
  logic                 pkt_c;
  logic signed [8:0]    dx9;
  logic signed [8:0]    dy9;
  logic signed [DW-1:0] jx_c;
  logic signed [DW-1:0] jy_c;
  logic signed [DW-1:0] raw_x_c;
  logic signed [DW-1:0] raw_y_c;
  logic signed [DW-1:0] inc_x_c;
  logic signed [DW-1:0] inc_y_c;
  logic                 dir_x;
  logic                 clk_x;
  logic                 dir_y;
  logic                 clk_y;
  logic                 unused_bits;

  assign unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3:0]};
  assign tick_c      = (cnt_q == CNT_W'(STEP_DIV - 1));
  assign pkt_c       = armed_q && (strobe_q != ps2_mouse[24]) && !hold;

  // Prescaler, strobe history and the one-clock arming delay after reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      cnt_q    <= tick_c ? '0 : cnt_q + CNT_W'(1);
      strobe_q <= ps2_mouse[24];
      armed_q  <= 1'b1;
    end
  end

  // Per-axis increment: packet delta plus optional joystick nudge, negated when flipped.
  always_comb begin
    dx9  = {ps2_mouse[4], ps2_mouse[15:8]};
    dy9  = {ps2_mouse[5], ps2_mouse[23:16]};
    jx_c = '0;
    jy_c = '0;
`ifdef TRACKBALL_JOY_EN
    if (tick_c) begin
      if (joy_i[3]) jx_c = jx_c + DW'(1);
      if (joy_i[2]) jx_c = jx_c - DW'(1);
      if (joy_i[0]) jy_c = jy_c + DW'(1);
      if (joy_i[1]) jy_c = jy_c - DW'(1);
    end
`endif
    raw_x_c = jx_c;
    raw_y_c = jy_c;
    if (pkt_c) begin
      raw_x_c = raw_x_c + DW'(dx9);
      raw_y_c = raw_y_c + DW'(dy9);
    end
    inc_x_c = flip ? -raw_x_c : raw_x_c;
    inc_y_c = flip ? -raw_y_c : raw_y_c;
  end

  trackball_axis #(.ACC_W(ACC_W)) u_axis_x (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .tick     (tick_c),
    .hold     (hold),
    .inc      (inc_x_c),
    .dir      (dir_x),
    .step_clk (clk_x)
  );

  trackball_axis #(.ACC_W(ACC_W)) u_axis_y (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .tick     (tick_c),
    .hold     (hold),
    .inc      (inc_y_c),
    .dir      (dir_y),
    .step_clk (clk_y)
  );

  assign trakdata = {dir_x, clk_x, dir_y, clk_y};

endmodule

// File: tb/tb_trackball_quad.sv
// Directed bench for trackball_quad: packets, flip, reversal, saturation, reset, hold, joystick.
module tb_trackball_quad;

  localparam int unsigned SD  = 8;
  localparam int unsigned AW  = 12;
  localparam int          SDI = 8;

  logic        clk_sys   = 1'b0;
  logic        reset_n   = 1'b0;
  logic [24:0] ps2_mouse = '0;
  logic        flip      = 1'b0;
  logic        hold      = 1'b0;
  logic [3:0]  trakdata;
`ifdef TRACKBALL_JOY_EN
  logic [3:0]  joy_i     = '0;
`endif

  trackball_quad #(.ACC_W(AW), .STEP_DIV(SD)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_mouse (ps2_mouse),
    .flip      (flip),
    .hold      (hold),
`ifdef TRACKBALL_JOY_EN
    .joy_i     (joy_i),
`endif
    .trakdata  (trakdata)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Edge monitor: toggle counts, minimum event spacing, dir/clk coincidence.
  int         cyc      = 0;
  int         xtog     = 0;
  int         ytog     = 0;
  int         gap_err  = 0;
  int         same_chg = 0;
  int         last_x   = -1000;
  int         last_y   = -1000;
  logic [3:0] prev_td  = '0;

  always @(negedge clk_sys) begin
    cyc = cyc + 1;
    if (reset_n) begin
      if (trakdata[3:2] != prev_td[3:2]) begin
        if (cyc - last_x < SDI) gap_err++;
        last_x = cyc;
      end
      if (trakdata[1:0] != prev_td[1:0]) begin
        if (cyc - last_y < SDI) gap_err++;
        last_y = cyc;
      end
      if (trakdata[2] != prev_td[2]) xtog++;
      if (trakdata[0] != prev_td[0]) ytog++;
      if ((trakdata[3] != prev_td[3]) && (trakdata[2] != prev_td[2])) same_chg++;
      if ((trakdata[1] != prev_td[1]) && (trakdata[0] != prev_td[0])) same_chg++;
    end
    prev_td = trakdata;
  end

  logic tog = 1'b0;

  task automatic send_pkt(input logic xs, input logic [7:0] xm,
                          input logic ys, input logic [7:0] ym);
    tog = ~tog;
    ps2_mouse = {tog, ym, xm, 2'b00, ys, xs, 4'b0000};
    @(negedge clk_sys);
  endtask

  task automatic sync_tick();
    int n = 0;
    @(negedge clk_sys);
    while (dut.tick_c !== 1'b1 && n < 4 * SDI) begin
      @(negedge clk_sys);
      n++;
    end
    check("sync_tick", int'(dut.tick_c), 1);
    @(negedge clk_sys);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  int xs0;
  int ys0;

  initial begin
    repeat (3) @(negedge clk_sys);
    check("reset_trakdata", int'(trakdata), 0);
    check("reset_acc_x", int'($signed(dut.u_axis_x.acc_q)), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // +5 on X: one SETUP then five toggles
    xs0 = xtog;
    send_pkt(1'b0, 8'd5, 1'b0, 8'd0);
    repeat (8 * SD) @(negedge clk_sys);
    check("pos_xtog", xtog - xs0, 5);
    check("pos_trakdata", int'(trakdata), 4'b1100);
    check("pos_acc_x", int'($signed(dut.u_axis_x.acc_q)), 0);

    // Y=+3 flipped becomes -3; dir_y already 0 so steps start at once
    flip = 1'b1;
    xs0 = xtog;
    ys0 = ytog;
    send_pkt(1'b0, 8'd0, 1'b0, 8'd3);
    repeat (5 * SD) @(negedge clk_sys);
    flip = 1'b0;
    check("flip_ytog", ytog - ys0, 3);
    check("flip_xtog", xtog - xs0, 0);
    check("flip_trakdata", int'(trakdata), 4'b1101);
    check("flip_acc_y", int'($signed(dut.u_axis_y.acc_q)), 0);

    // +2 then -4 back-to-back between ticks
    sync_tick();
    xs0 = xtog;
    send_pkt(1'b0, 8'd2, 1'b0, 8'd0);
    send_pkt(1'b1, 8'hFC, 1'b0, 8'd0);
    check("rev_acc_x", int'($signed(dut.u_axis_x.acc_q)), -2);
    repeat (4 * SD) @(negedge clk_sys);
    check("rev_xtog", xtog - xs0, 2);
    check("rev_trakdata", int'(trakdata), 4'b0101);
    check("rev_same_chg", same_chg, 0);

    // 20 x +255 clamps at 2047; tick edges 8 (SETUP) and 16 (STEP) fall inside
    sync_tick();
    for (int i = 0; i < 20; i++) send_pkt(1'b0, 8'd255, 1'b0, 8'd0);
    check("sat_acc_x", int'($signed(dut.u_axis_x.acc_q)), 2047);
    hold = 1'b1;
    @(negedge clk_sys);
    hold = 1'b0;
    check("sat_hold_clear", int'($signed(dut.u_axis_x.acc_q)), 0);
    repeat (2 * SD) @(negedge clk_sys);
    check("sat_trakdata", int'(trakdata), 4'b1001);

    // Asynchronous reset mid-step, then strobe high through release
    send_pkt(1'b0, 8'd10, 1'b0, 8'd0);
    repeat (2 * SD + 2) @(negedge clk_sys);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_trakdata", int'(trakdata), 0);
    check("async_rst_acc_x", int'($signed(dut.u_axis_x.acc_q)), 0);
    tog = 1'b1;
    ps2_mouse = {1'b1, 24'h000000};
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    xs0 = xtog;
    ys0 = ytog;
    repeat (4 * SD) @(negedge clk_sys);
    check("strobe_rst_trakdata", int'(trakdata), 0);
    check("strobe_rst_toggles", (xtog - xs0) + (ytog - ys0), 0);
    check("strobe_rst_acc_x", int'($signed(dut.u_axis_x.acc_q)), 0);

    // Hold: packet ignored, outputs frozen, no burst on release
    send_pkt(1'b0, 8'd1, 1'b0, 8'd0);
    repeat (3 * SD) @(negedge clk_sys);
    check("hold_pre_trakdata", int'(trakdata), 4'b1100);
    hold = 1'b1;
    xs0 = xtog;
    ys0 = ytog;
    send_pkt(1'b0, 8'd10, 1'b0, 8'd10);
    repeat (4 * SD) @(negedge clk_sys);
    check("hold_trakdata", int'(trakdata), 4'b1100);
    check("hold_acc_x", int'($signed(dut.u_axis_x.acc_q)), 0);
    check("hold_acc_y", int'($signed(dut.u_axis_y.acc_q)), 0);
    hold = 1'b0;
    repeat (4 * SD) @(negedge clk_sys);
    check("hold_rel_toggles", (xtog - xs0) + (ytog - ys0), 0);
    check("hold_rel_trakdata", int'(trakdata), 4'b1100);

`ifdef TRACKBALL_JOY_EN
    // Right for exactly 10 ticks: IDLE, SETUP, 8 steps, then 2 to drain
    do_reset();
    sync_tick();
    xs0 = xtog;
    ys0 = ytog;
    joy_i = 4'b1000;
    repeat (10 * SD) @(negedge clk_sys);
    joy_i = 4'b0000;
    repeat (4 * SD) @(negedge clk_sys);
    check("joy_right_xtog", xtog - xs0, 10);
    check("joy_right_dir_x", int'(trakdata[3]), 1);
    check("joy_right_ytog", ytog - ys0, 0);
    xs0 = xtog;
    joy_i = 4'b1100;
    repeat (5 * SD) @(negedge clk_sys);
    joy_i = 4'b0000;
    repeat (2 * SD) @(negedge clk_sys);
    check("joy_cancel_xtog", xtog - xs0, 0);
    check("joy_cancel_acc_x", int'($signed(dut.u_axis_x.acc_q)), 0);
`endif

    check("gap_err", gap_err, 0);
    check("same_chg", same_chg, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
